ifetch_queue: RTL
=================

// Module: ifetch_queue
// PURPOSE
//   Instruction fetch stage placed directly upstream of the word-aligned instruction memory.
//   It owns the fetch PC and drives the memory word address.
//   It captures the combinational read data and the matching PC into a small prefetch FIFO.
//   It presents instructions to decode over a valid/ready handshake.
//   A redirect from the branch/jump unit flushes the FIFO and restarts fetch.
// PARAMETERS
//   DEPTH     4       FIFO entries; power of 2, >= 2
//   AW        6       instruction memory word-address width (64 words)
//   RESET_PC  32'h0   fetch PC loaded on reset
// PORTS
//   clk          in   1      clock; all state updates on rising edge
//   reset        in   1      synchronous, active-high reset
//   imem_addr    out  AW     word address to instruction memory = fetch_pc[AW+1:2]
//   imem_rd      in   32     instruction word read combinationally from imem_addr
//   redirect     in   1      flush and restart fetch at redirect_pc
//   redirect_pc  in   32     new fetch PC; bits [1:0] ignored (forced to 0)
//   instr_valid  out  1      head entry valid
//   instr_ready  in   1      decode accepts head this cycle
//   instr        out  32     head instruction word
//   instr_pc     out  32     PC of head instruction
//   count        out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Only state: fetch_pc, head/tail pointers, count, DEPTH x {instr,pc} storage. There is no other FSM.
//   - imem_addr is combinational from fetch_pc. Memory read is zero-latency, so data is sampled in the same cycle.
//   - pop  = instr_valid & instr_ready.
//   - push = ~redirect & ((count < DEPTH) | pop).
//   - On push: mem[tail] <= {imem_rd, fetch_pc}; tail++; fetch_pc <= fetch_pc + 4.
//   - On pop: head++. count updates by push - pop each cycle.
//   - Push and pop in the same cycle at full is legal: count stays DEPTH, and the write slot is the one freed by the pop.
//   - Empty: no bypass. A fetched word reaches instr_valid one cycle after the fetch cycle.
//     Minimum latency from reset release or redirect to first instr_valid is 1 cycle after the first fetch.
//   - instr_valid = (count != 0).
//   - instr and instr_pc read the head combinationally and are driven 32'h0 when count == 0.
//   - Priority per edge: reset > redirect > normal push/pop.
//   - reset: fetch_pc <= RESET_PC; head = tail = count = 0; no push or pop.
//     Outputs after the edge: instr_valid = 0, instr = 0, instr_pc = 0, imem_addr = RESET_PC[AW+1:2].
//     Reset mid-stream discards all entries.
//   - redirect: head = tail = count = 0; fetch_pc <= {redirect_pc[31:2], 2'b00}; no push.
//     A pop in the same cycle is a don't-care, because the entry is flushed anyway.
//     Next cycle: instr_valid = 0. The following cycle presents the instruction at the redirect target.
//   - fetch_pc wraps modulo 2^32. imem_addr wraps modulo 2^AW words; address aliasing is memory behaviour, not an error.
//   - Held redirect stalls fetch, and fetch_pc reloads every cycle.
//   - instr_ready = 0 with a full FIFO stalls fetch. fetch_pc and imem_addr hold.
// TESTING
//   Preload imem word n = 32'hA000_0000 + n for all of the tests below.
//   1. Reset 2 cycles, then instr_ready = 0 for 6 cycles.
//      -> count = 4, fetch_pc = 16, imem_addr = 4, instr = 32'hA000_0000, instr_pc = 0; all hold.
//   2. Reset release with instr_ready = 1 held.
//      -> instr_valid first high 1 cycle after release.
//      -> instr_pc = 0, 4, 8, ... on consecutive cycles with no bubbles; count stays 1.
//   3. Fill to count = 4, then one cycle with instr_ready = 1.
//      -> head advances to instr_pc = 4; word 4 is pushed; count stays 4; fetch_pc = 20.
//   4. Full FIFO, redirect = 1, redirect_pc = 32'h0000_0043 for 1 cycle.
//      -> next cycle count = 0, instr_valid = 0, imem_addr = 16.
//      -> following cycle instr = 32'hA000_0010, instr_pc = 32'h40.
//   5. Redirect to 32'h0000_00FC, instr_ready = 1.
//      -> imem_addr = 63, instr_pc = 32'hFC.
//      -> next fetch_pc = 32'h100, imem_addr = 0, instr_pc = 32'h100 with instr = 32'hA000_0000.
//   6. Reset asserted mid-stream with instr_ready toggling and redirect asserted in the same cycle.
//      -> reset wins: count = 0, fetch_pc = RESET_PC, instr = 0, instr_pc = 0 after the edge.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// Fetch-to-memory and fetch-to-decode signal bundle for ifetch_queue.
// The master modport is the fetch queue; the slave modport is the memory/decode side.
interface ifetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 6
);
  logic [AW-1:0]            imem_addr;
  logic [31:0]              imem_rd;
  logic                     redirect;
  logic [31:0]              redirect_pc;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [31:0]              instr;
  logic [31:0]              instr_pc;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output imem_addr, instr_valid, instr, instr_pc, count,
    input  imem_rd, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_addr, instr_valid, instr, instr_pc, count,
    output imem_rd, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, samples zero-latency memory data
// into a small prefetch FIFO and hands instructions to decode; redirect flushes.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  ifetch_queue_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic          nonempty_s;
  logic          pop_s;
  logic          push_s;
  logic [1:0]    unused_pc_lsb_s;

  assign nonempty_s      = (count_q != {CW{1'b0}});
  assign pop_s           = nonempty_s & bus.instr_ready;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign push_s          = ~bus.redirect & ((count_q < CW'(DEPTH)) | pop_s);
  assign unused_pc_lsb_s = bus.redirect_pc[1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      head_d     = {PW{1'b0}};
      tail_d     = {PW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      if (push_s) begin
        tail_d     = tail_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        tail_d     = tail_q;
        fetch_pc_d = fetch_pc_q;
      end
      if (pop_s) begin
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage carries no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      instr_mem_q[tail_q] <= bus.imem_rd;
      pc_mem_q[tail_q]    <= fetch_pc_q;
    end
  end

  assign bus.imem_addr   = fetch_pc_q[AW+1:2];
  assign bus.instr_valid = nonempty_s;
  assign bus.instr       = nonempty_s ? instr_mem_q[head_q] : 32'h0;
  assign bus.instr_pc    = nonempty_s ? pc_mem_q[head_q]    : 32'h0;
  assign bus.count       = count_q;
endmodule
